approx_adder_pipe_mon: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-input/5-output approximate adders produced by the XPAT flow.
- Computes an approximate sum of two WIDTH-bit operands in a runtime-selectable mode, and the exact sum alongside it.
- Measures the absolute error of every result against the error threshold ET and keeps saturating statistics.
- Sits in the evaluation harness between a stimulus source and a result sink, both using valid/ready.

---
 rtl/approx_adder_pkg.sv | 66 ++++++
 rtl/approx_adder_pipe_mon_err_stats.sv | 61 ++++++
 rtl/approx_adder_pipe_mon.sv | 119 +++++++++++
 tb/tb_approx_adder_pipe_mon.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_adder_pkg
// Description : Mode encoding and the approximate-sum function shared by the
//               approximate adder pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package approx_adder_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOA   = 2'd1,
        MODE_TRUNC = 2'd2
    } mode_e;

    // Operands are zero-extended to this width before entering approx_sum,
    // so callers must keep WIDTH <= APPROX_MAX_W.
    localparam int unsigned APPROX_MAX_W = 32;

    // Approximate sum of the low `width` bits of a and b; the low `lpp` bits
    // are approximated. Mode 3 falls through to the exact sum.
    function automatic logic [APPROX_MAX_W:0] approx_sum(
        input logic [APPROX_MAX_W-1:0] a,
        input logic [APPROX_MAX_W-1:0] b,
        input logic [1:0]              mode,
        input int unsigned             width,
        input int unsigned             lpp
    );
        logic [APPROX_MAX_W-1:0] width_mask;
        logic [APPROX_MAX_W-1:0] lo_mask;
        logic [APPROX_MAX_W-1:0] a_m;
        logic [APPROX_MAX_W-1:0] b_m;
        logic                    carry;
        logic [APPROX_MAX_W:0]   hi_sum;
        logic [APPROX_MAX_W:0]   carry_in;
        logic [APPROX_MAX_W:0]   result;

        width_mask = '0;
        lo_mask    = '0;
        carry      = 1'b0;
        for (int unsigned i = 0; i < APPROX_MAX_W; i++) begin
            width_mask[i] = (i < width);
            lo_mask[i]    = (i < lpp);
            if (i + 1 == lpp) begin
                carry = a[i] & b[i];
            end
        end

        a_m = a & width_mask;
        b_m = b & width_mask;

        // The upper operands keep their bit positions, so the carry is simply
        // injected at weight 2**lpp.
        hi_sum   = {1'b0, a_m & ~lo_mask} + {1'b0, b_m & ~lo_mask};
        carry_in = {{APPROX_MAX_W{1'b0}}, carry} << lpp;

        case (mode)
            MODE_LOA:   result = (hi_sum + carry_in) | {1'b0, (a_m | b_m) & lo_mask};
            MODE_TRUNC: result = hi_sum;
            default:    result = {1'b0, a_m} + {1'b0, b_m};
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_adder_pipe_mon_err_stats.sv
`default_nettype none
// ============================================================================
// Module      : approx_err_stats
// Description : Saturating sample/violation counters, running maximum error
//               and sticky threshold flag, updated on each output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_err_stats #(
    parameter int unsigned ERR_W = 5,
    parameter int unsigned ET    = 14,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             xfer,
    input  logic [ERR_W-1:0] err,
    output logic [CNT_W-1:0] stat_samples,
    output logic [CNT_W-1:0] stat_viol,
    output logic [ERR_W-1:0] stat_max_err,
    output logic             et_violation
);

    logic [CNT_W-1:0] r_samples;
    logic [CNT_W-1:0] r_viol;
    logic [ERR_W-1:0] r_max_err;
    logic             r_et_violation;
    logic             w_over;

    assign w_over = (64'(err) > 64'(ET));

    // clear takes priority over a coinciding transfer, which is then not counted.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_samples      <= '0;
            r_viol         <= '0;
            r_max_err      <= '0;
            r_et_violation <= 1'b0;
        end else if (xfer) begin
            if (r_samples != '1) begin
                r_samples <= r_samples + CNT_W'(1);
            end
            if (w_over) begin
                if (r_viol != '1) begin
                    r_viol <= r_viol + CNT_W'(1);
                end
                r_et_violation <= 1'b1;
            end
            if (err > r_max_err) begin
                r_max_err <= err;
            end
        end
    end

    assign stat_samples = r_samples;
    assign stat_viol    = r_viol;
    assign stat_max_err = r_max_err;
    assign et_violation = r_et_violation;

endmodule
`default_nettype wire

// File: rtl/approx_adder_pipe_mon.sv
`default_nettype none
// ============================================================================
// Module      : approx_adder_pipe_mon
// Description : Two-stage valid/ready approximate adder (exact/LOA/truncate)
//               with exact reference sum, absolute error and error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_adder_pipe_mon
    import approx_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LPP   = 2,
    parameter int unsigned ET    = 14,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_exact,
    output logic [WIDTH:0]   out_err,
    input  logic             clear,
    output logic [CNT_W-1:0] stat_samples,
    output logic [CNT_W-1:0] stat_viol,
    output logic [WIDTH:0]   stat_max_err,
    output logic             et_violation
);

    localparam int unsigned c_sum_w = WIDTH + 1;

    logic               w_en;
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_mode;

    logic [c_sum_w-1:0] w_exact;
    logic [c_sum_w-1:0] w_approx;
    logic [c_sum_w:0]   w_diff;
    logic [c_sum_w-1:0] w_err;

    logic               r_out_valid;
    logic [c_sum_w-1:0] r_sum;
    logic [c_sum_w-1:0] r_exact;
    logic [c_sum_w-1:0] r_err;

    // Single global enable: both stages advance together or both hold.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= MODE_EXACT;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_mode <= in_mode;
            end
        end
    end

    assign w_exact  = {1'b0, r_a} + {1'b0, r_b};
    assign w_approx = c_sum_w'(approx_sum(APPROX_MAX_W'(r_a), APPROX_MAX_W'(r_b),
                                          r_mode, WIDTH, LPP));

    // One extra bit so the sign of exact - approx is never lost.
    assign w_diff = {1'b0, w_exact} - {1'b0, w_approx};
    assign w_err  = w_diff[c_sum_w] ? c_sum_w'(-w_diff) : c_sum_w'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_exact     <= '0;
            r_err       <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum   <= w_approx;
                r_exact <= w_exact;
                r_err   <= w_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_exact = r_exact;
    assign out_err   = r_err;

    approx_err_stats #(
        .ERR_W (c_sum_w),
        .ET    (ET),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .xfer         (r_out_valid && out_ready),
        .err          (r_err),
        .stat_samples (stat_samples),
        .stat_viol    (stat_viol),
        .stat_max_err (stat_max_err),
        .et_violation (et_violation)
    );

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_adder_pipe_mon
// Description : Directed vectors and corner sequences for approx_adder_pipe_mon
//               on default, LPP=4 and CNT_W=2 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_adder_pipe_mon;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- default instance (W=4, LPP=2, ET=14, CNT_W=16)
    logic        rst, in_valid, in_ready, out_valid, out_ready, clear, et_violation;
    logic [3:0]  in_a, in_b;
    logic [1:0]  in_mode;
    logic [4:0]  out_sum, out_exact, out_err, stat_max_err;
    logic [15:0] stat_samples, stat_viol;

    approx_adder_pipe_mon u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_exact(out_exact), .out_err(out_err),
        .clear(clear), .stat_samples(stat_samples), .stat_viol(stat_viol),
        .stat_max_err(stat_max_err), .et_violation(et_violation)
    );

    // ---------------- LPP=4 instance
    logic        rst_4, in_valid_4, in_ready_4, out_valid_4, out_ready_4, clear_4, et_4;
    logic [3:0]  in_a_4, in_b_4;
    logic [1:0]  in_mode_4;
    logic [4:0]  out_sum_4, out_exact_4, out_err_4, max_4;
    logic [15:0] samples_4, viol_4;

    approx_adder_pipe_mon #(.WIDTH(4), .LPP(4), .ET(14), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .in_a(in_a_4), .in_b(in_b_4), .in_mode(in_mode_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .out_sum(out_sum_4), .out_exact(out_exact_4), .out_err(out_err_4),
        .clear(clear_4), .stat_samples(samples_4), .stat_viol(viol_4),
        .stat_max_err(max_4), .et_violation(et_4)
    );

    // ---------------- CNT_W=2 instance (LPP=4 so truncation can exceed ET)
    logic        rst_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c, clear_c, et_c;
    logic [3:0]  in_a_c, in_b_c;
    logic [1:0]  in_mode_c;
    logic [4:0]  out_sum_c, out_exact_c, out_err_c, max_c;
    logic [1:0]  samples_c, viol_c;

    approx_adder_pipe_mon #(.WIDTH(4), .LPP(4), .ET(14), .CNT_W(2)) u_dutc (
        .clk(clk), .rst(rst_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_a(in_a_c), .in_b(in_b_c), .in_mode(in_mode_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_sum(out_sum_c), .out_exact(out_exact_c), .out_err(out_err_c),
        .clear(clear_c), .stat_samples(samples_c), .stat_viol(viol_c),
        .stat_max_err(max_c), .et_violation(et_c)
    );

    typedef struct {
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic [4:0] exact;
        logic [4:0] err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge where the beat's result is on the outputs.
    task automatic send_d(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_mode = m; in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_4(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_mode_4 = m; in_a_4 = a; in_b_4 = b; in_valid_4 = 1'b1;
        @(negedge clk);
        in_valid_4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          exp_samples;
        logic [4:0]  exp_max;
        bit          acc;
        int          beat;
        int          ngot;
        logic [4:0]  got [4];

        //            mode  a      b      sum    exact  err
        vecs[0] = '{2'd1, 4'd3,  4'd1,  5'd3,  5'd4,  5'd1};
        vecs[1] = '{2'd1, 4'd15, 4'd15, 5'd31, 5'd30, 5'd1};
        vecs[2] = '{2'd2, 4'd3,  4'd3,  5'd0,  5'd6,  5'd6};
        vecs[3] = '{2'd0, 4'd9,  4'd8,  5'd17, 5'd17, 5'd0};
        vecs[4] = '{2'd1, 4'd5,  4'd6,  5'd11, 5'd11, 5'd0};
        vecs[5] = '{2'd2, 4'd15, 4'd15, 5'd24, 5'd30, 5'd6};
        vecs[6] = '{2'd3, 4'd7,  4'd9,  5'd16, 5'd16, 5'd0};
        vecs[7] = '{2'd1, 4'd2,  4'd2,  5'd6,  5'd4,  5'd2};
        vecs[8] = '{2'd2, 4'd12, 4'd1,  5'd12, 5'd13, 5'd1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
        out_ready = 1'b1; clear = 1'b0;
        rst_4 = 1'b1; in_valid_4 = 1'b0; in_a_4 = '0; in_b_4 = '0; in_mode_4 = '0;
        out_ready_4 = 1'b1; clear_4 = 1'b0;
        rst_c = 1'b1; in_valid_c = 1'b0; in_a_c = '0; in_b_c = '0; in_mode_c = '0;
        out_ready_c = 1'b1; clear_c = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_4 = 1'b0; rst_c = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_err", out_err, 0);
        check("rst_samples", stat_samples, 0);
        check("rst_max_err", stat_max_err, 0);
        check("rst_et_violation", et_violation, 0);

        // Directed vectors, one beat at a time with out_ready held high.
        exp_samples = 0;
        exp_max     = '0;
        for (int i = 0; i < 9; i++) begin
            send_d(vecs[i].mode, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
            check($sformatf("vec%0d_exact", i), out_exact, vecs[i].exact);
            check($sformatf("vec%0d_err", i), out_err, vecs[i].err);
            @(negedge clk);
            exp_samples++;
            if (vecs[i].err > exp_max) exp_max = vecs[i].err;
            check($sformatf("vec%0d_samples", i), stat_samples, exp_samples);
            check($sformatf("vec%0d_max_err", i), stat_max_err, exp_max);
            check($sformatf("vec%0d_et", i), et_violation, 0);
            check($sformatf("vec%0d_drained", i), out_valid, 0);
        end
        check("vec_viol", stat_viol, 0);

        // clear coinciding with an output handshake wins.
        send_d(2'd1, 4'd3, 4'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_samples", stat_samples, 0);
        check("clr_max_err", stat_max_err, 0);
        check("clr_viol", stat_viol, 0);
        send_d(2'd2, 4'd3, 4'd3);
        @(negedge clk);
        check("clr_next_samples", stat_samples, 1);
        check("clr_next_max_err", stat_max_err, 6);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Backpressure: four exact-mode beats (sums 1..4), sink stalls cycles 0..4.
        acc  = 1'b0;
        beat = 0;
        ngot = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_mode = 2'd0; in_a = 4'd1; in_b = 4'd0; in_valid = 1'b1;
            end else if (acc) begin
                beat++;
                if (beat < 4) in_a = 4'(beat + 1);
                else          in_valid = 1'b0;
            end
            out_ready = (c >= 5);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (ngot < 4) got[ngot] = out_sum;
                ngot++;
            end
            if (c >= 2 && c <= 4) begin
                check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
                check($sformatf("bp_hold_valid_c%0d", c), out_valid, 1);
                check($sformatf("bp_hold_sum_c%0d", c), out_sum, 1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", ngot, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_order%0d", k), got[k], k + 1);
        end
        check("bp_samples", stat_samples, 4);

        // LPP=4 instance: full truncation violates, flag is sticky until clear.
        send_4(2'd2, 4'd15, 4'd15);
        check("l4_trunc_sum", out_sum_4, 0);
        check("l4_trunc_err", out_err_4, 30);
        @(negedge clk);
        check("l4_viol", viol_4, 1);
        check("l4_et", et_4, 1);
        send_4(2'd0, 4'd1, 4'd1);
        check("l4_exact_err", out_err_4, 0);
        @(negedge clk);
        check("l4_et_sticky", et_4, 1);
        check("l4_viol_hold", viol_4, 1);
        check("l4_max_err", max_4, 30);
        send_4(2'd1, 4'd15, 4'd15);
        check("l4_loa_sum", out_sum_4, 31);
        @(negedge clk);
        clear_4 = 1'b1;
        @(negedge clk);
        clear_4 = 1'b0;
        check("l4_clr_et", et_4, 0);
        check("l4_clr_viol", viol_4, 0);
        check("l4_clr_samples", samples_4, 0);

        // CNT_W=2 instance: counters saturate at 3.
        @(negedge clk);
        in_mode_c = 2'd2; in_a_c = 4'd15; in_b_c = 4'd15; in_valid_c = 1'b1;
        repeat (5) @(negedge clk);
        in_valid_c = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_samples", samples_c, 3);
        check("sat_viol", viol_c, 3);
        check("sat_et", et_c, 1);
        check("sat_max_err", max_c, 30);

        // rst while a result is stalled at the output drops it.
        @(negedge clk);
        in_valid_c = 1'b1;
        @(negedge clk);
        in_valid_c = 1'b0;
        @(negedge clk);
        check("rst_stall_valid_before", out_valid_c, 1);
        out_ready_c = 1'b0;
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        check("rst_stall_valid", out_valid_c, 0);
        check("rst_stall_samples", samples_c, 0);
        check("rst_stall_viol", viol_c, 0);
        check("rst_stall_et", et_c, 0);
        check("rst_stall_in_ready", in_ready_c, 1);
        out_ready_c = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stall_no_beat", out_valid_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
